// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, an optional
// 2-entry skid buffer and a flush that turns every held entry into a bubble.
module pipe_stage_skid_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_nxt, k_ctrl, k_ctrl_nxt;
    logic [DATA_W-1:0] m_data, m_data_nxt, k_data, k_data_nxt;
    logic              m_valid;
    logic              rdy_q;
    logic [OCC_W-1:0]  occ_q, occ_nxt;
    logic              in_xfer, out_xfer;

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign occupancy = occ_q;

    // Skid build breaks the ready path with a register; single-entry build passes it through.
    assign in_ready = (SKID != 0) ? rdy_q : (!m_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = m_valid && out_ready;

    // Next-state and next-register values.
    always_comb begin
        state_nxt  = state;
        m_ctrl_nxt = m_ctrl;
        m_data_nxt = m_data;
        k_ctrl_nxt = k_ctrl;
        k_data_nxt = k_data;
        occ_nxt    = OCC_W'(0);

        if (flush) begin
            state_nxt  = ST_EMPTY;
            m_ctrl_nxt = '0;
            m_data_nxt = '0;
            k_ctrl_nxt = '0;
            k_data_nxt = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt  = ST_FULL;
                        m_ctrl_nxt = in_ctrl;
                        m_data_nxt = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        m_ctrl_nxt = in_ctrl;
                        m_data_nxt = in_data;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_nxt  = ST_SKID;
                        k_ctrl_nxt = in_ctrl;
                        k_data_nxt = in_data;
                    end else if (out_xfer) begin
                        state_nxt  = ST_EMPTY;
                        m_ctrl_nxt = '0;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_nxt  = ST_FULL;
                        m_ctrl_nxt = k_ctrl;
                        m_data_nxt = k_data;
                        k_ctrl_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end

        case (state_nxt)
            ST_FULL: occ_nxt = OCC_W'(1);
            ST_SKID: occ_nxt = OCC_W'(2);
            default: occ_nxt = OCC_W'(0);
        endcase
    end

    // State and storage registers; reset wins over flush and both transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            m_ctrl  <= '0;
            m_data  <= '0;
            k_ctrl  <= '0;
            k_data  <= '0;
            m_valid <= 1'b0;
            rdy_q   <= 1'b1;
            occ_q   <= OCC_W'(0);
        end else begin
            state   <= state_nxt;
            m_ctrl  <= m_ctrl_nxt;
            m_data  <= m_data_nxt;
            k_ctrl  <= k_ctrl_nxt;
            k_data  <= k_data_nxt;
            m_valid <= (state_nxt != ST_EMPTY);
            rdy_q   <= (state_nxt != ST_SKID);
            occ_q   <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus a randomized run
// against queue models of both the skid (depth 2) and single-entry builds.
module tb_pipe_stage_skid_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 128;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk;
    logic          rst, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          s1_in_ready, s1_out_valid;
    logic [CW-1:0] s1_out_ctrl;
    logic [DW-1:0] s1_out_data;
    logic [1:0]    s1_occ;

    logic          s0_in_ready, s0_out_valid;
    logic [CW-1:0] s0_out_ctrl;
    logic [DW-1:0] s0_out_data;
    logic [1:0]    s0_occ;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_ctrl(s1_out_ctrl), .out_data(s1_out_data),
        .occupancy(s1_occ)
    );

    pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_ctrl(s0_out_ctrl), .out_data(s0_out_data),
        .occupancy(s0_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_chk++; if (s1_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", s1_out_valid); end
        n_chk++; if (s1_out_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", s1_out_ctrl); end
        n_chk++; if (s1_out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", s1_out_data); end
        n_chk++; if (s1_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", s1_occ); end
        n_chk++; if (s1_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", s1_in_ready); end
        n_chk++; if (s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready0 got=%0b exp=1", s0_in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_ctrl = CW'(8'h10 + k); in_data = DW'(k);
            @(negedge clk);
            n_chk++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== CW'(8'h10 + k) || s1_out_data !== DW'(k)) begin
                n_fail++; $display("FAIL stream_out k=%0d got v=%0b c=%h d=%0h exp v=1 c=%h d=%0h",
                                   k, s1_out_valid, s1_out_ctrl, s1_out_data, CW'(8'h10 + k), k);
            end
            n_chk++; if (s1_occ !== 2'd1 || s1_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_occ k=%0d got occ=%0d rdy=%0b exp occ=1 rdy=1", k, s1_occ, s1_in_ready);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00 || s1_occ !== 2'd0) begin
            n_fail++; $display("FAIL stream_drain got v=%0b c=%h occ=%0d exp v=0 c=00 occ=0", s1_out_valid, s1_out_ctrl, s1_occ);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hA1; in_data = DW'(32'hA1);
        @(negedge clk);
        in_ctrl = 8'hA2; in_data = DW'(32'hA2);
        @(negedge clk);
        n_chk++; if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0 || s1_out_ctrl !== 8'hA1) begin
            n_fail++; $display("FAIL bp_skid got occ=%0d rdy=%0b c=%h exp occ=2 rdy=0 c=a1", s1_occ, s1_in_ready, s1_out_ctrl);
        end
        in_ctrl = 8'hA3; in_data = DW'(32'hA3);
        @(negedge clk);
        n_chk++; if (s1_occ !== 2'd2 || s1_out_ctrl !== 8'hA1 || s1_out_data !== DW'(32'hA1)) begin
            n_fail++; $display("FAIL bp_hold got occ=%0d c=%h exp occ=2 c=a1", s1_occ, s1_out_ctrl);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (s1_out_ctrl !== 8'hA2 || s1_occ !== 2'd1 || s1_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_drain1 got c=%h occ=%0d rdy=%0b exp c=a2 occ=1 rdy=1", s1_out_ctrl, s1_occ, s1_in_ready);
        end
        @(negedge clk);
        n_chk++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 8'hA3 || s1_out_data !== DW'(32'hA3)) begin
            n_fail++; $display("FAIL bp_a3 got v=%0b c=%h exp v=1 c=a3", s1_out_valid, s1_out_ctrl);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (s1_out_valid !== 1'b0 || s1_occ !== 2'd0) begin
            n_fail++; $display("FAIL bp_empty got v=%0b occ=%0d exp v=0 occ=0", s1_out_valid, s1_occ);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hB1; in_data = DW'(32'hB1);
        @(negedge clk);
        in_ctrl = 8'hB2; in_data = DW'(32'hB2);
        @(negedge clk);
        n_chk++; if (s1_occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre got occ=%0d exp=2", s1_occ); end
        flush = 1'b1; in_ctrl = 8'hB3; in_data = DW'(32'hB3);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00 || s1_out_data !== '0 || s1_occ !== 2'd0 || s1_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_state got v=%0b c=%h occ=%0d rdy=%0b exp v=0 c=00 occ=0 rdy=1",
                               s1_out_valid, s1_out_ctrl, s1_occ, s1_in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00) begin
            n_fail++; $display("FAIL flush_no_b3 got v=%0b c=%h exp v=0 c=00", s1_out_valid, s1_out_ctrl);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hD1; in_data = DW'(32'hD1);
        @(negedge clk);
        in_ctrl = 8'hD2;
        @(negedge clk);
        n_chk++; if (s1_occ !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre got occ=%0d exp=2", s1_occ); end
        rst = 1'b1; flush = 1'b1; in_ctrl = 8'hE0;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 8'h00 || s1_out_data !== '0 || s1_occ !== 2'd0 || s1_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_state got v=%0b c=%h occ=%0d rdy=%0b exp v=0 c=00 occ=0 rdy=1",
                               s1_out_valid, s1_out_ctrl, s1_occ, s1_in_ready);
        end
        in_valid = 1'b1; in_ctrl = 8'hC0; in_data = DW'(32'hC0);
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 8'hC0 || s1_occ !== 2'd1) begin
            n_fail++; $display("FAIL rstmid_c0 got v=%0b c=%h occ=%0d exp v=1 c=c0 occ=1", s1_out_valid, s1_out_ctrl, s1_occ);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (s1_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_alone got v=%0b exp=0", s1_out_valid); end
    endtask

    task automatic test_skid0();
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = DW'(32'h5A);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++; if (s0_out_valid !== 1'b1 || s0_out_ctrl !== 8'h5A || s0_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL s0_stall got v=%0b c=%h rdy=%0b exp v=1 c=5a rdy=0", s0_out_valid, s0_out_ctrl, s0_in_ready);
        end
        out_ready = 1'b1;
        #1;
        n_chk++; if (s0_in_ready !== 1'b1) begin n_fail++; $display("FAIL s0_comb_ready got=%0b exp=1", s0_in_ready); end
        in_valid = 1'b1; in_ctrl = 8'h5B; in_data = DW'(32'h5B);
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (s0_out_valid !== 1'b1 || s0_out_ctrl !== 8'h5B || s0_out_data !== DW'(32'h5B) || s0_occ !== 2'd1) begin
            n_fail++; $display("FAIL s0_replace got v=%0b c=%h occ=%0d exp v=1 c=5b occ=1", s0_out_valid, s0_out_ctrl, s0_occ);
        end
        @(negedge clk);
        n_chk++; if (s0_out_valid !== 1'b0 || s0_out_ctrl !== 8'h00) begin
            n_fail++; $display("FAIL s0_empty got v=%0b c=%h exp v=0 c=00", s0_out_valid, s0_out_ctrl);
        end
    endtask

    // Both builds driven together; each is modelled as a bounded FIFO.
    task automatic test_random();
        ent_t q1[$];
        ent_t q0[$];
        ent_t e, h;
        logic r1, r0;
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            h = (q1.size() > 0) ? q1[0] : '0;
            n_chk++; if (s1_out_valid !== (q1.size() > 0) || s1_out_ctrl !== h.c || s1_occ !== 2'(q1.size())
                         || s1_in_ready !== (q1.size() < 2)) begin
                n_fail++; $display("FAIL rand_s1 cyc=%0d got v=%0b c=%h occ=%0d rdy=%0b exp v=%0b c=%h occ=%0d",
                                   cyc, s1_out_valid, s1_out_ctrl, s1_occ, s1_in_ready, q1.size() > 0, h.c, q1.size());
            end
            if (q1.size() > 0) begin
                n_chk++; if (s1_out_data !== h.d) begin
                    n_fail++; $display("FAIL rand_s1_data cyc=%0d got=%h exp=%h", cyc, s1_out_data, h.d);
                end
            end
            h = (q0.size() > 0) ? q0[0] : '0;
            n_chk++; if (s0_out_valid !== (q0.size() > 0) || s0_out_ctrl !== h.c || s0_occ !== 2'(q0.size())) begin
                n_fail++; $display("FAIL rand_s0 cyc=%0d got v=%0b c=%h occ=%0d exp v=%0b c=%h occ=%0d",
                                   cyc, s0_out_valid, s0_out_ctrl, s0_occ, q0.size() > 0, h.c, q0.size());
            end
            if (q0.size() > 0) begin
                n_chk++; if (s0_out_data !== h.d) begin
                    n_fail++; $display("FAIL rand_s0_data cyc=%0d got=%h exp=%h", cyc, s0_out_data, h.d);
                end
            end

            in_valid  = ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 55);
            flush     = ($urandom_range(99) < 3);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            e.c = in_ctrl; e.d = in_data;
            #1;
            r1 = (q1.size() < 2);
            r0 = (q0.size() == 0) || out_ready;
            n_chk++; if (s0_in_ready !== r0) begin
                n_fail++; $display("FAIL rand_s0_ready cyc=%0d got=%0b exp=%0b", cyc, s0_in_ready, r0);
            end

            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (out_ready && q1.size() > 0) void'(q1.pop_front());
                if (in_valid && r1) q1.push_back(e);
                if (out_ready && q0.size() > 0) void'(q0.pop_front());
                if (in_valid && r0) q0.push_back(e);
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_skid0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generalised inter-stage pipeline register for the ARM pipeline. It carries a control field and a data field from one stage to the next.
- It replaces the fixed enable/clear register style with a valid/ready handshake and an optional 2-entry skid buffer, so back-pressure from a downstream stage does not need a combinational stall path upstream.
- A flush squashes every held entry and turns it into a bubble. Flush is used on taken branches and hazards.

Parameters:
- CTRL_W, 8, width of the control field (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, …). Forced to 0 on bubble or flush.
- DATA_W, 128, width of the data field (PC, Val_Rn, Val_Rm, operands). Forced to 0 on flush or reset.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  out_ctrl/out_data hold a valid entry.
- out_ready  in  1  downstream accepts the entry.
- out_ctrl  out  CTRL_W  control field; 0 whenever out_valid=0.
- out_data  out  DATA_W  data field.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Transfer events:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
- Storage and outputs:
  - Main register (M) and skid register (K), each with a valid bit.
  - out_* are driven directly from M; there is no combinational in→out path.
- Latency: 1 cycle. An entry accepted at edge N appears on out_* after edge N when the stage was empty.
- Reset (rst=1 at edge) drives:
  - M.valid=0, K.valid=0, M/K ctrl and data = 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides flush and both transfers.
  - Reset mid-operation discards all entries with no partial output.
- Flush (rst=0, flush=1 at edge):
  - Same register effect as reset.
  - Any same-cycle in_xfer is dropped (the input is squashed).
  - A same-cycle out_xfer completes downstream; the stage itself simply empties.
- Invariant: out_ctrl is 0 when out_valid=0, always; the stage never presents stale control.
- State machine for SKID=1 (no rst, no flush):
  - EMPTY (occ 0):
    - in_xfer → FULL, M<=in.
  - FULL (occ 1):
    - in_xfer & out_xfer → FULL, M<=in.
    - in_xfer & !out_xfer → SKID, K<=in.
    - !in_xfer & out_xfer → EMPTY, M ctrl<=0.
    - otherwise → hold.
  - SKID (occ 2):
    - out_xfer → FULL, M<=K, K ctrl<=0.
    - otherwise → hold.
  - in_ready = (state != SKID), driven from a register.
- SKID=0:
  - K absent.
  - in_ready = !out_valid | out_ready (combinational).
  - in_xfer loads M.
  - out_xfer without in_xfer empties M.
- Handshake rules:
  - Once out_valid=1, out_ctrl/out_data stay stable until out_xfer, flush or rst.
  - Input entries presented while in_ready=0 are not captured.
  - Order is FIFO; no entry is duplicated or lost except by flush/rst.
- Width rules:
  - Fields are copied bit-exact; no arithmetic.
  - CTRL_W ≥ 1 and DATA_W ≥ 1 are required.

Test Plan:
- Reset then stream: rst 2 cycles, then in_valid=1 with in_ctrl=8'h11..8'h14 and in_data=k on 4 consecutive cycles, out_ready=1 → out_valid rises 1 cycle after first accept; outputs are 11,12,13,14 on consecutive cycles; occupancy stays 1; in_ready stays 1.
- Back-pressure (SKID=1): FULL holding ctrl 8'hA1, out_ready=0, push 8'hA2 → occupancy=2, in_ready=0 next cycle. Push 8'hA3 (not captured). out_ready=1 for 2 cycles → A1 then A2 out, in_ready=1 after the first drain, A3 accepted only after in_ready returns.
- Flush with simultaneous input: SKID state holding B1,B2; flush=1 with in_valid=1 and in_ctrl=8'hB3 → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; B3 never appears.
- Reset mid-stream overrides flush: occupancy=2, rst=1 and flush=1 with in_valid=1 → all outputs 0 next cycle; first post-reset accepted entry 8'hC0 appears alone.
- SKID=0 build: out_valid=1, out_ready=0 → in_ready=0 the same cycle. Set out_ready=1 → in_ready=1 combinationally; an entry accepted that cycle replaces the output with no bubble.
- Bubble invariant: random in_valid/out_ready/flush over 10k cycles against a FIFO model → order preserved, out_ctrl==0 whenever out_valid==0, occupancy matches the model.
